// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder for ten game keys: prefix FSM, live key bitmap and FWFT event FIFO.
// Optional macro PS2_UNKNOWN_EN pushes 8'hFF for every unrecognised decode.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES  = 250000,
   parameter int FIFO_DEPTH      = 4,
   parameter int SUPPRESS_REPEAT = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_convert,
   output logic [7:0] o_code,
   output logic       o_code_valid,
   input  logic       i_code_ready,
   output logic [9:0] o_keys,
   output logic       o_overflow,
   output logic       o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t           state, eff_state, nxt_state;
   logic [CNT_W-1:0] cnt;
   logic             tmo_hit;
   logic             dec_en, dec_rel, dec_ext;
   logic             key_hit, suppress;
   logic [3:0]       key_idx;
   logic [7:0]       ev_code;
   logic             push_req, push_ok, pop, full;
   logic [7:0]       push_data;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;

   // Returns {recognised, index}; arrows only match behind E0, the rest only without it.
   function automatic logic [4:0] lookup(input logic ext, input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      if (ext) begin
         case (b)
            8'h75:   r = 5'h14;
            8'h72:   r = 5'h15;
            8'h6B:   r = 5'h16;
            8'h74:   r = 5'h17;
            default: r = 5'd0;
         endcase
      end else begin
         case (b)
            8'h1D:   r = 5'h10;
            8'h1B:   r = 5'h11;
            8'h1C:   r = 5'h12;
            8'h23:   r = 5'h13;
            8'h5A:   r = 5'h18;
            8'h29:   r = 5'h19;
            default: r = 5'd0;
         endcase
      end
      return r;
   endfunction

   // A byte landing on the timeout cycle is interpreted as if the FSM were already idle.
   always_comb begin
      tmo_hit   = (state != S_IDLE) && (cnt == TMO_LAST);
      eff_state = tmo_hit ? S_IDLE : state;
      nxt_state = eff_state;
      dec_en    = 1'b0;
      dec_rel   = 1'b0;
      dec_ext   = 1'b0;
      if (i_convert) begin
         case (eff_state)
            S_IDLE: begin
               case (i_data)
                  8'hE0:                      nxt_state = S_EXT;
                  8'hF0:                      nxt_state = S_BRK;
                  8'hFA, 8'hAA, 8'hEE, 8'hFE: nxt_state = S_IDLE;
                  default:                    dec_en    = 1'b1;
               endcase
            end
            S_EXT: begin
               if (i_data == 8'hF0) begin
                  nxt_state = S_EXT_BRK;
               end else if (i_data != 8'hE0) begin
                  dec_en    = 1'b1;
                  dec_ext   = 1'b1;
                  nxt_state = S_IDLE;
               end
            end
            S_BRK: begin
               dec_en    = 1'b1;
               dec_rel   = 1'b1;
               nxt_state = S_IDLE;
            end
            default: begin
               dec_en    = 1'b1;
               dec_rel   = 1'b1;
               dec_ext   = 1'b1;
               nxt_state = S_IDLE;
            end
         endcase
      end
   end

   assign {key_hit, key_idx} = lookup(dec_ext, i_data);
   assign ev_code  = {dec_rel, 2'b00, dec_ext, key_idx};
   assign suppress = !dec_rel && (SUPPRESS_REPEAT != 0) && o_keys[key_idx];

`ifdef PS2_UNKNOWN_EN
   assign push_req  = dec_en && (key_hit ? !suppress : 1'b1);
   assign push_data = key_hit ? ev_code : 8'hFF;
`else
   assign push_req  = dec_en && key_hit && !suppress;
   assign push_data = ev_code;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         o_timeout <= 1'b0;
         o_keys    <= '0;
      end else begin
         state     <= nxt_state;
         o_timeout <= tmo_hit;
         if (i_convert || nxt_state == S_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (dec_en && key_hit)
            o_keys[key_idx] <= !dec_rel;
      end
   end

   // Event FIFO: a pop frees a slot in the same cycle, so a full FIFO still accepts then.
   assign o_code_valid = (count != '0);
   assign full         = (count == FULL_CNT);
   assign pop          = o_code_valid && i_code_ready;
   assign push_ok      = push_req && (!full || pop);
   assign o_code       = o_code_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge i_clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
         if (push_req && !push_ok)
            o_overflow <= 1'b1;
      end
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 250000: idle cycles after a prefix byte before the partial sequence is abandoned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO depth; power of two, 2..16.
REQ-003 SHALL have parameter SUPPRESS_REPEAT, default 1: 1 drops typematic repeat presses of keys already down.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_data, input, 8: received PS/2 scan-code byte.
REQ-007 SHALL have port i_convert, input, 1: one-cycle strobe; i_data is valid in that cycle.
REQ-008 SHALL have port o_code, output, 8: head-of-FIFO event {release, 2'b00, special, index[3:0]}.
REQ-009 SHALL have port o_code_valid, output, 1: FIFO not empty; o_code is valid.
REQ-010 SHALL have port i_code_ready, input, 1: consumer pops the head when o_code_valid and i_code_ready are both high.
REQ-011 SHALL have port o_keys, output, 10: live key-down bitmap, bit n = key index n.
REQ-012 SHALL have port o_overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.
REQ-013 SHALL have port o_timeout, output, 1: one-cycle pulse when a partial sequence is abandoned.

Function
REQ-014 SHALL map keys to index and special bit as follows:
- W 1D->0, S 1B->1, A 1C->2, D 23->3: special=0.
- UP 75->4, DOWN 72->5, LEFT 6B->6, RIGHT 74->7: special=1, E0-prefixed.
- ENTER 5A->8, SPACE 29->9: special=0.
REQ-015 SHALL use states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0,F0 seen), and process each strobed byte in its strobe cycle.
REQ-016 SHALL make these transitions:
- IDLE: E0->EXT, F0->BRK; bytes FA, AA, EE, FE are ignored; any other byte is a make code, decoded, stay IDLE.
- EXT: F0->EXT_BRK; E0 stays EXT; any other byte is a special make, decoded, ->IDLE.
- BRK: any byte is a break code, decoded, ->IDLE.
- EXT_BRK: any byte is a special break, decoded, ->IDLE.
REQ-017 SHALL set the release bit for BRK/EXT_BRK decodes, and SHALL match special=1 only for EXT/EXT_BRK decodes with arrow codes and special=0 only for non-prefixed codes; any other combination is unrecognised.
REQ-018 SHALL, for a recognised make, set o_keys[index]; with SUPPRESS_REPEAT=1 and the bit already set, no event is pushed.
REQ-019 SHALL, for a recognised break, clear o_keys[index] and push a release event.
REQ-020 SHALL update o_keys whether or not the FIFO accepts the event.
REQ-021 SHALL run a timeout counter in every non-IDLE state:
- The counter clears on each strobe.
- On reaching TIMEOUT_CYCLES-1 the state returns to IDLE, o_timeout pulses and no event is pushed.
REQ-022 SHALL, if a strobe coincides with the timeout cycle, abandon the partial sequence and interpret the byte from IDLE.
REQ-023 SHALL implement the FIFO as first-word-fall-through, with one cycle of latency from the final-byte strobe edge to o_code_valid when the FIFO is empty.
REQ-024 SHALL, when the FIFO is full, drop the new event and set o_overflow; if a pop occurs in the same cycle, the push is accepted instead.
REQ-025 SHALL, on a push and pop in the same cycle, leave the occupancy unchanged and keep the event order.
REQ-026 SHALL hold o_code stable while o_code_valid is high and i_code_ready is low.

Reset
REQ-027 SHALL, when i_rst is high at a clock edge, set:
- state to IDLE and the counter to 0;
- the FIFO to empty, o_code_valid=0, o_code=8'h00;
- o_keys=0, o_overflow=0, o_timeout=0.
REQ-028 SHALL discard a sequence that is in progress at reset, and SHALL ignore i_convert in a reset cycle.

Configuration
REQ-029 SHALL, with macro PS2_UNKNOWN_EN defined, push event 8'hFF for every unrecognised decode; o_keys is unaffected.
REQ-030 SHALL, without PS2_UNKNOWN_EN, drop unrecognised decodes silently; no FIFO logic for 8'hFF is generated.

Verification
REQ-031 SHALL cover: strobe 1D, ready=1 -> o_code=00 with valid one cycle later; o_keys[0]=1; then F0,1D -> 80; o_keys[0]=0.
REQ-032 SHALL cover: E0,75 then E0,F0,75 -> events 14 then 94; o_keys[4] set then cleared.
REQ-033 SHALL cover: SUPPRESS_REPEAT=1, strobes 29,29,29 -> single event 09; with SUPPRESS_REPEAT=0 -> three 09 events.
REQ-034 SHALL cover: E0, then no strobe for TIMEOUT_CYCLES cycles, then 75 -> o_timeout pulse once, then event 00? no; event none for 75 unrecognised non-special (8'hFF only with PS2_UNKNOWN_EN).
REQ-035 SHALL cover: ready=0, FIFO_DEPTH=4, five make/break events -> four events retained in order, o_overflow=1; push with simultaneous pop at full is accepted.
REQ-036 SHALL cover: i_rst pulsed after F0 strobe, then 1C -> event 02 (press), o_overflow=0.
